// File: rtl/module_bcd_pkg.sv
// ============================================================================
// Module      : module_bcd_pkg
// Description : Shared types and constants for the binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package module_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  localparam int BCD_DIGIT_W     = 4;
  localparam int BCD_ADD3_THRESH = 5;

  // Used at elaboration to confirm DIGITS decimal places can hold 2^WIDTH-1.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/module_bcd_add3.sv
// ============================================================================
// Module      : module_bcd_add3
// Description : Double-dabble correction cell: adds 3 to a digit that is >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_bcd_add3
  import module_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // 4-bit wrap is harmless: a legal digit (<= 9) plus 3 never exceeds 12.
  assign digit_out = (digit_in >= BCD_DIGIT_W'(BCD_ADD3_THRESH))
                   ? digit_in + BCD_DIGIT_W'(3)
                   : digit_in;

endmodule

`default_nettype wire

// File: rtl/module_bin_to_bcd.sv
// ============================================================================
// Module      : module_bin_to_bcd
// Description : Sequential shift-and-add-3 binary-to-BCD converter, one bit
//               per clock, with start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_bin_to_bcd
  import module_bcd_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          ready,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  generate
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
      $error("module_bin_to_bcd: DIGITS too small for WIDTH");
    end
  endgenerate

  bcd_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [BCD_W-1:0]       w_corr;
  logic [BCD_W+WIDTH-1:0] w_cat;
  logic [BCD_W-1:0]       w_work_next;
  logic [WIDTH-1:0]       w_bin_next;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      module_bcd_add3 u_add3 (
        .digit_in  (work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (w_corr[i*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Binary MSB shifts into digit 0 bit 0 after correction.
  assign w_cat       = {w_corr, bin_sr_q} << 1;
  assign w_work_next = w_cat[BCD_W+WIDTH-1:WIDTH];
  assign w_bin_next  = w_cat[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_sr_d = bin_sr_q;
    work_d   = work_q;
    bcd_d    = bcd_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_sr_d = bin;
          work_d   = '0;
          cnt_d    = CNT_LOAD;
          state_d  = SHIFT;
          ready_d  = 1'b0;
        end
      end
      SHIFT: begin
        work_d   = w_work_next;
        bin_sr_d = w_bin_next;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          bcd_d   = w_work_next;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_sr_q <= '0;
      work_q   <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_sr_q <= bin_sr_d;
      work_q   <= work_d;
      bcd_q    <= bcd_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign bcd   = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_module_bin_to_bcd.sv
// ============================================================================
// Module      : tb_module_bin_to_bcd
// Description : Scoreboard bench for module_bin_to_bcd with decimal reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_module_bin_to_bcd;

  localparam int WIDTH  = 12;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] bin   = '0;
  logic             ready;
  logic             done;
  logic [BCD_W-1:0] bcd;

  module_bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BCD_W-1:0] exp;
    int               acc;
  } item_t;

  item_t            q[$];
  int               checks    = 0;
  int               failures  = 0;
  int               cycle     = 0;
  int               last_acc  = 0;
  bit               have_acc  = 1'b0;
  int               acc_count = 0;
  logic [BCD_W-1:0] last_bcd  = '0;

  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference protocol: idle until WIDTH edges after an accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      have_acc = 1'b0;
      last_bcd = '0;
    end else begin
      cycle++;
      if (start && (!have_acc || cycle > last_acc + WIDTH)) begin
        q.push_back('{ref_bcd(int'(bin)), cycle});
        last_acc = cycle;
        have_acc = 1'b1;
        acc_count++;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check(ready == (!have_acc || cycle >= last_acc + WIDTH), "ready",
            int'(ready), int'(!have_acc || cycle >= last_acc + WIDTH));
      if (done) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_done", int'(bcd), 0);
        end else begin
          item_t it;
          it = q.pop_front();
          check(bcd == it.exp, "bcd_value", int'(bcd), int'(it.exp));
          check(cycle - it.acc == WIDTH, "latency", cycle - it.acc, WIDTH);
          for (int d = 0; d < DIGITS; d++) begin
            check(bcd[4*d +: 4] <= 4'd9, "digit_range", int'(bcd[4*d +: 4]), 9);
          end
        end
        last_bcd = bcd;
      end else begin
        check(bcd == last_bcd, "bcd_stable", int'(bcd), int'(last_bcd));
        if (q.size() != 0 && cycle - q[0].acc >= WIDTH) begin
          check(1'b0, "missing_done", int'(done), 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check(1'b0, "idle_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  // Assumes the caller is just after a falling edge; returns one cycle after acceptance.
  task automatic convert(input int v);
    int a;
    int n;
    a     = acc_count;
    n     = 0;
    bin   = WIDTH'(v);
    start = 1'b1;
    while (acc_count == a && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (acc_count == a) check(1'b0, "accept_timeout", v, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check(bcd == '0, "reset_bcd", int'(bcd), 0);
    check(ready == 1'b1, "reset_ready", int'(ready), 1);
    check(done == 1'b0, "reset_done", int'(done), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    convert(0);    wait_idle(); check(bcd == 16'h0000, "dir_0",    int'(bcd), 16'h0000);
    convert(1234); wait_idle(); check(bcd == 16'h1234, "dir_1234", int'(bcd), 16'h1234);
    convert(4095); wait_idle(); check(bcd == 16'h4095, "dir_4095", int'(bcd), 16'h4095);
    convert(9);    wait_idle(); check(bcd == 16'h0009, "dir_9",    int'(bcd), 16'h0009);

    // start held high; bin changes mid-conversion
    start = 1'b1;
    bin   = WIDTH'(100);
    @(negedge clk);
    bin = WIDTH'(250);
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();
    check(bcd == 16'h0250, "held_start_250", int'(bcd), 16'h0250);

    // Asynchronous reset during a conversion
    convert(42); wait_idle(); check(bcd == 16'h0042, "dir_42", int'(bcd), 16'h0042);
    convert(777);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(bcd == '0, "abort_bcd", int'(bcd), 0);
    check(ready == 1'b1, "abort_ready", int'(ready), 1);
    check(done == 1'b0, "abort_done", int'(done), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    convert(777); wait_idle(); check(bcd == 16'h0777, "dir_777", int'(bcd), 16'h0777);

    // Exhaustive sweep, start kept high so each accept lands in the done cycle
    for (int i = 0; i < (1 << WIDTH); i++) begin
      convert(i);
    end
    wait_idle();

    // Random start/bin traffic
    for (int i = 0; i < 2000; i++) begin
      start = 1'($urandom_range(0, 1));
      bin   = WIDTH'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
